// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared sizes, glyph patterns and frame type for the seven-segment scan driver
package seg_scan_pkg;
    localparam int NUM_TUBES = 8;
    localparam int CODE_W = 4;
    localparam int IDX_W = 3;
    localparam logic [7:0] SEG_0 = 8'hFC;
    localparam logic [7:0] SEG_1 = 8'h60;
    localparam logic [7:0] SEG_2 = 8'hDA;
    localparam logic [7:0] SEG_3 = 8'hF2;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'hB6;
    localparam logic [7:0] SEG_6 = 8'hBE;
    localparam logic [7:0] SEG_7 = 8'hE0;
    localparam logic [7:0] SEG_8 = 8'hFE;
    localparam logic [7:0] SEG_9 = 8'hF6;
    localparam logic [7:0] SEG_A = 8'hEE;
    localparam logic [7:0] SEG_B = 8'h3E;
    localparam logic [7:0] SEG_C = 8'h9C;
    localparam logic [7:0] SEG_D = 8'h7A;
    localparam logic [7:0] SEG_E = 8'h9E;
    localparam logic [7:0] SEG_F = 8'h8E;
    typedef struct packed {
        logic [NUM_TUBES*CODE_W-1:0] data;
        logic [NUM_TUBES-1:0]        blank;
        logic [NUM_TUBES-1:0]        blink;
        logic [NUM_TUBES-1:0]        dp;
    } frame_t;
    localparam frame_t FRAME_RESET = '{data: '0, blank: '1, blink: '0, dp: '0};
endpackage

// File: rtl/seg_glyph_decoder.sv
// seg_glyph_decoder: 4-bit glyph code to {a..g,dp} segment pattern, dp left clear
module seg_glyph_decoder
    import seg_scan_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [7:0]        seg
);
    // Hex glyph lookup
    always_comb begin
        case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered eight-tube scan driver; blinking built only with SEG_SCAN_BLINK_EN
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] frame_data,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  blink_mask,
    input  logic [7:0]  dp_mask,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        frame_done,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx, idx_n;
    frame_t            shadow, active, active_n, offered;
    logic              shadow_full, shadow_full_n;
    logic              tick, boundary, accept, blink_ph_n, dark;
    logic [7:0]        blink_in, glyph, seg;

    assign tick = scan_cnt == SCAN_W'(SCAN_DIV - 1);
    assign boundary = tick && idx == IDX_W'(NUM_TUBES - 1);
    assign accept = frame_valid && frame_ready;
    assign idx_n = tick ? idx + 1'b1 : idx;
    assign active_n = boundary && shadow_full ? shadow : active;
    assign shadow_full_n = accept ? 1'b1 : boundary ? 1'b0 : shadow_full;
    assign offered = '{data: frame_data, blank: blank_mask, blink: blink_in, dp: dp_mask};

`ifdef SEG_SCAN_BLINK_EN
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph, blink_wrap;
    assign blink_wrap = blink_cnt == BLINK_W'(BLINK_HALF - 1);
    assign blink_ph_n = blink_wrap ? !blink_ph : blink_ph;
    assign blink_in = blink_mask;
    // Free-running blink phase, toggled every half-period
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_ph  <= blink_ph_n;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask;
    assign blink_ph_n = 1'b0;
    assign blink_in = '0;
`endif

    seg_glyph_decoder u_dec (
        .code (active_n.data[idx_n*CODE_W +: CODE_W]),
        .seg  (glyph)
    );

    assign dark = active_n.blank[idx_n] || (blink_ph_n && active_n.blink[idx_n]);
    assign seg = dark ? 8'h00 : glyph | {7'b0, active_n.dp[idx_n]};

    // Scan position, shadow load on handshake, promotion at the frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt    <= '0;
            idx         <= '0;
            shadow      <= FRAME_RESET;
            shadow_full <= 1'b0;
            active      <= FRAME_RESET;
        end else begin
            scan_cnt    <= tick ? '0 : scan_cnt + 1'b1;
            idx         <= idx_n;
            shadow      <= accept ? offered : shadow;
            shadow_full <= shadow_full_n;
            active      <= active_n;
        end
    end

    // Outputs registered from next-state values so the promoted frame shows on the boundary edge
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            tube_sel    <= '0;
            digit1      <= '0;
            digit2      <= '0;
        end else begin
            frame_ready <= !shadow_full_n;
            frame_done  <= boundary;
            tube_sel    <= enable ? 8'b1 << idx_n : 8'h00;
            digit1      <= enable && idx_n[2] ? seg : 8'h00;
            digit2      <= enable && !idx_n[2] ? seg : 8'h00;
        end
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's eight seven-segment tubes, split into two four-tube groups. It accepts a double-buffered frame of eight 4-bit glyph codes through a valid/ready handshake. It scans one tube at a time and produces the `digit1`/`digit2`/`tube_sel` signals that the top-level display mux routes to the pins. It is the producer end of the display interface, so the time, self-clean, smoker and gesture blocks supply only frame contents instead of doing their own scanning.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `SCAN_HZ`, 1000: per-tube dwell rate. `SCAN_DIV = CLK_HZ/SCAN_HZ` must be ≥ 2.
- `BLINK_HZ`, 2: blink rate. Half-period is `CLK_HZ/(2*BLINK_HZ)` cycles.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `enable`  in  1  display on (machine_state).
- `frame_data`  in  32  glyph codes; nibble i, `[4i+3:4i]`, drives tube i.
- `blank_mask`  in  8  bit i=1 blanks tube i.
- `blink_mask`  in  8  bit i=1 blinks tube i.
- `dp_mask`  in  8  bit i=1 lights the decimal point of tube i.
- `frame_valid`  in  1  producer offers a frame.
- `frame_ready`  out  1  shadow buffer empty.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.
- `digit1`  out  8  segments for tubes 7..4, active-high, `{a,b,c,d,e,f,g,dp}` with a in bit 7.
- `digit2`  out  8  segments for tubes 3..0, same encoding.
- `tube_sel`  out  8  one-hot, active-high; bit i selects tube i.

## Operation
**Buffers**
- Two buffers: shadow and active. Each holds data, blank, blink and dp masks.
- Accept rule: a frame is accepted when `frame_valid & frame_ready`. The shadow buffer is loaded and marked full.
- `frame_ready = !shadow_full`.

**Scan**
- The scan counter counts 0..SCAN_DIV-1. A tick occurs on the count SCAN_DIV-1, then the counter wraps to 0.
- On each tick, tube index `idx` advances 0→1→…→7→0.
- Frame boundary: a tick with `idx==7`.
- At a frame boundary:
  - `frame_done` pulses.
  - If shadow is full: active ← shadow, and shadow_full clears.
  - If shadow is empty: active is unchanged.

**Outputs**
- `tube_sel = 1<<idx`.
- Segments come from the active buffer entry `idx`. They go on `digit1` if idx ≥ 4, otherwise on `digit2`. The other group output is 8'h00.
- Glyph decode: 0–9 decimal; A, b, C, d, E, F for 0xA–0xF. Example: 0 → 8'hFC, 8 → 8'hFE.
- The dp bit comes from `dp_mask`.
- Tube is dark (segments 8'h00, `tube_sel` still asserted) when either:
  - its blank bit is set, or
  - blink phase is 1 and its blink bit is set.
- Blink phase toggles every half-period.
- `enable=0`:
  - `digit1`, `digit2` and `tube_sel` are forced to 0.
  - Scan, blink and the handshake keep running.

## Timing
**Reset values** (`rst` high, sampled at clk edge):
- `idx`=0, scan counter=0, blink phase=0.
- shadow_full=0. `frame_ready` is 0 while `rst` is high and 1 on the first cycle after.
- Active buffer: data 0, blank 8'hFF, blink 0, dp 0.
- `digit1`=`digit2`=`tube_sel`=8'h00, `frame_done`=0.
- Reset asserted mid-frame discards both buffers.

**Output latency**
- All outputs are registered.
- `tube_sel` and segments change on the edge that ends a tick cycle.
- At a boundary, tube 0 shows the newly promoted frame on that same edge.
- Outside reset, `tube_sel` is 8'h01 from the first cycle after reset, provided `enable`=1.

**Handshake and boundary corner cases**
- A frame accepted on the boundary cycle itself (shadow empty) stays in shadow until the next boundary.
- When shadow is full, ready=0, so an accept and a promotion never occur in the same cycle.
- `enable` affects the outputs on the next edge.

## Configuration
- `SEG_SCAN_BLINK_EN` defined: blink counter and blink masking present.
- Undefined: no blink counter is built and `blink_mask` is ignored. `blank_mask` still applies.

## Structure
- Shared package `seg_scan_pkg`:
  - `NUM_TUBES=8`, `CODE_W=4`.
  - Glyph constants `SEG_0`…`SEG_F`.
  - A frame struct type for data and the three masks.
- One sub-module, `seg_glyph_decoder`: combinational code → 7-segment decoder, instantiated once on the active entry selected by `idx`.

## Test plan
Bench parameters: CLK_HZ=800, SCAN_HZ=100 (SCAN_DIV=8), BLINK_HZ=1 (blink half-period 400 cycles).
1. Reset release, no frame → `tube_sel` steps 01,02,…,80 every 8 cycles, all segments 0, `frame_done` every 64 cycles, `frame_ready`=1.
2. Frame 32'h8765_4321, masks 0 → after the next boundary:
   - tube 0 shows `digit2`=SEG_1, `digit1`=0.
   - tube 7 shows `digit1`=8'hFE, `digit2`=0.
3. Two frames back-to-back → first accepted, `frame_ready` drops, second is held until the boundary promotes the first. The second becomes visible one frame later.
4. `blink_mask`=8'h01 → tube 0 segments present for 400 cycles, then 0 for 400, repeating. Other tubes unaffected.
5. `enable` 1→0 mid-frame → all outputs 0 next cycle. On `enable`=1, scanning resumes at the current `idx` with no frame lost.
6. `rst` pulsed while shadow is full → `frame_ready`=1 after reset, display dark, `idx`=0.
